ahb_led_sequencer: RTL

AHB-Lite master that plays a programmable 8-entry LED pattern into the LED peripheral slave by issuing single 32-bit write transfers at a fixed step interval. It sits on the AHB-Lite bus beside the CPU master, behind the bus arbiter/multiplexer. It lets the LED output animate without CPU involvement. Pattern entries, loop length and step period are loaded through a simple local port.

---
 rtl/ahb_led_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ahb_led_sequencer.sv
// ahb_led_sequencer: AHB-Lite master playing an 8-entry LED pattern into the LED peripheral at a fixed step interval.
// Define LED_SEQ_MASK_EN to precede each pattern write with a mask write of mask_data to BASE_ADDR+4.
module ahb_led_sequencer #(
  parameter logic [31:0] BASE_ADDR = 32'h5000_0000,
  parameter int DEPTH = 8
) (
  input  logic        HCLK,
  input  logic        HRESET,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
`ifdef LED_SEQ_MASK_EN
  input  logic [7:0]  mask_data,
`endif
  input  logic        pat_we,
  input  logic [2:0]  pat_addr,
  input  logic [7:0]  pat_data,
  input  logic [2:0]  last_idx,
  input  logic [23:0] period,
  input  logic        start,
  input  logic        stop,
  output logic        busy,
  output logic        step_done,
  output logic [2:0]  cur_idx
);
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] IDLE_TR = 2'b00;
  typedef enum logic [2:0] {
    IDLE, ADDR, DATA, WAIT
`ifdef LED_SEQ_MASK_EN
    , MADDR, MDATA
`endif
  } state_t;
`ifdef LED_SEQ_MASK_EN
  localparam state_t FIRST = MADDR;
  localparam logic [31:0] FIRST_ADDR = BASE_ADDR + 32'd4;
`else
  localparam state_t FIRST = ADDR;
  localparam logic [31:0] FIRST_ADDR = BASE_ADDR;
`endif
  state_t state, state_n;
  logic [7:0] pat_mem [DEPTH];
  logic [2:0] idx, idx_n, last, last_n, cur_n;
  logic [23:0] per, per_n, cnt, cnt_n;
  logic stop_pend, pend_n, hwrite_n, done_n;
  logic [31:0] haddr_n, hwdata_n;
  logic [1:0] htrans_n;
  assign HSIZE = 3'b010;
  assign busy = state != IDLE;
  // table is not reset; a same-cycle write to the entry being fetched yields the old value
  always_ff @(posedge HCLK)
    if (pat_we) pat_mem[pat_addr] <= pat_data;
  always_comb begin
    state_n = state;
    idx_n = idx;
    last_n = last;
    per_n = per;
    cnt_n = cnt;
    pend_n = stop_pend;
    haddr_n = HADDR;
    htrans_n = HTRANS;
    hwrite_n = HWRITE;
    hwdata_n = HWDATA;
    done_n = 1'b0;
    cur_n = cur_idx;
    case (state)
      IDLE: if (start && !stop) begin
        state_n = FIRST;
        idx_n = '0;
        last_n = last_idx;
        per_n = period;
        pend_n = 1'b0;
        haddr_n = FIRST_ADDR;
        htrans_n = NONSEQ;
        hwrite_n = 1'b1;
      end
      ADDR: begin
        pend_n = stop_pend | stop;
        if (HREADY) begin
          state_n = DATA;
          htrans_n = IDLE_TR;
          hwrite_n = 1'b0;
          hwdata_n = {24'h0, pat_mem[idx]};
        end
      end
      DATA: begin
        pend_n = stop_pend | stop;
        if (HREADY) begin
          done_n = 1'b1;
          cur_n = idx;
          if (stop_pend || stop) begin
            state_n = IDLE;
            pend_n = 1'b0;
          end else begin
            state_n = WAIT;
            cnt_n = (per == 24'd0) ? 24'd0 : per - 24'd1;
            idx_n = (idx == last) ? 3'd0 : idx + 3'd1;
          end
        end
      end
      WAIT: if (stop) state_n = IDLE;
      else if (cnt == 24'd0) begin
        state_n = FIRST;
        haddr_n = FIRST_ADDR;
        htrans_n = NONSEQ;
        hwrite_n = 1'b1;
      end else cnt_n = cnt - 24'd1;
`ifdef LED_SEQ_MASK_EN
      MADDR: begin
        pend_n = stop_pend | stop;
        if (HREADY) begin
          state_n = MDATA;
          htrans_n = IDLE_TR;
          hwrite_n = 1'b0;
          hwdata_n = {24'h0, mask_data};
        end
      end
      // a stop during the mask write ends the step before the pattern write
      MDATA: begin
        pend_n = stop_pend | stop;
        if (HREADY) begin
          if (stop_pend || stop) begin
            state_n = IDLE;
            pend_n = 1'b0;
          end else begin
            state_n = ADDR;
            haddr_n = BASE_ADDR;
            htrans_n = NONSEQ;
            hwrite_n = 1'b1;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state <= IDLE;
      idx <= '0;
      last <= '0;
      per <= '0;
      cnt <= '0;
      stop_pend <= 1'b0;
      HADDR <= '0;
      HTRANS <= IDLE_TR;
      HWRITE <= 1'b0;
      HWDATA <= '0;
      step_done <= 1'b0;
      cur_idx <= '0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      last <= last_n;
      per <= per_n;
      cnt <= cnt_n;
      stop_pend <= pend_n;
      HADDR <= haddr_n;
      HTRANS <= htrans_n;
      HWRITE <= hwrite_n;
      HWDATA <= hwdata_n;
      step_done <= done_n;
      cur_idx <= cur_n;
    end
endmodule
